// File: rtl/operand_io_pkg.sv
// Types, widths and the remainder-region offset shared by operand_io, the sequencer and the memories.
package operand_io_pkg;

  localparam int DATA_W  = 8;
  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 9;
  localparam int NUM_REQ = 4;

  localparam logic [ADDR_W-1:0] RESTO_BASE_DEFAULT = 9'h100;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RD_CAP,
    WR
  } state_e;

  // Encoding doubles as the bit index into the request vectors.
  typedef enum logic [1:0] {
    REQ_A,
    REQ_B,
    REQ_C,
    REQ_R
  } req_sel_e;

  function automatic logic is_load(input req_sel_e sel);
    return (sel == REQ_A) || (sel == REQ_B);
  endfunction

endpackage

// File: rtl/operand_io_req_arbiter.sv
// Served-flag tracking and fixed-priority selection (A > B > Resto > C) of pending requests.
module req_arbiter
  import operand_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic               valid_o,
  output req_sel_e           sel_o
);

  logic [NUM_REQ-1:0] served_q;
  logic [NUM_REQ-1:0] served_d;
  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] grant;

  assign pend = req_i & ~served_q;

  always_comb begin
    valid_o = 1'b1;
    sel_o   = REQ_A;
    if (pend[REQ_A])      sel_o = REQ_A;
    else if (pend[REQ_B]) sel_o = REQ_B;
    else if (pend[REQ_R]) sel_o = REQ_R;
    else if (pend[REQ_C]) sel_o = REQ_C;
    else                  valid_o = 1'b0;
  end

  // A flag survives only while its request stays high, so one assertion yields one transaction.
  always_comb begin
    grant        = '0;
    grant[sel_o] = accept_i;
    served_d     = req_i & (served_q | grant);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) served_q <= '0;
    else        served_q <= served_d;
  end

endmodule

// File: rtl/operand_io.sv
// Responds to the sequencer's register handshake: ROM byte loads onto A/B, result and
// remainder stores into RAM, and exactly one Fim pulse per served request.
module operand_io
  import operand_io_pkg::*;
#(
  parameter int                ROM_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESTO_BASE = RESTO_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EnA,
  input  logic              EnB,
  input  logic              EnC,
  input  logic              EnResto,
  input  logic [ADDR_W-1:0] Endereco,
  input  logic [WORD_W-1:0] result,
  input  logic [WORD_W-1:0] resto,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_wdata,
  output logic [WORD_W-1:0] A,
  output logic [WORD_W-1:0] B,
  output logic              FimA,
  output logic              FimB,
  output logic              FimC,
  output logic              FimResto,
  output logic              busy,
  output logic [7:0]        store_count
);

  localparam logic [1:0] LAT = 2'(ROM_LAT);

  state_e            state_q;
  req_sel_e          sel_q;
  req_sel_e          grant_sel;
  logic              grant_valid;
  logic              accept;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rom_addr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] rdata_q;
  logic [WORD_W-1:0] a_q;
  logic [WORD_W-1:0] b_q;
  logic [WORD_W-1:0] ram_wdata_q;
  logic [1:0]        cnt_q;
  logic              wr_done_q;
  logic              ram_we_q;
  logic              fim_a_q;
  logic              fim_b_q;
  logic              fim_c_q;
  logic              fim_r_q;
  logic [7:0]        store_count_q;

  assign accept = (state_q == IDLE) && grant_valid;

  req_arbiter u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    ({EnResto, EnC, EnB, EnA}),
    .accept_i (accept),
    .valid_o  (grant_valid),
    .sel_o    (grant_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= REQ_A;
      addr_q        <= '0;
      rom_addr_q    <= '0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      rdata_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      cnt_q         <= '0;
      wr_done_q     <= 1'b0;
      ram_we_q      <= 1'b0;
      fim_a_q       <= 1'b0;
      fim_b_q       <= 1'b0;
      fim_c_q       <= 1'b0;
      fim_r_q       <= 1'b0;
      store_count_q <= '0;
    end else begin
      ram_we_q <= 1'b0;
      fim_a_q  <= 1'b0;
      fim_b_q  <= 1'b0;
      fim_c_q  <= 1'b0;
      fim_r_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            sel_q     <= grant_sel;
            addr_q    <= Endereco;
            cnt_q     <= '0;
            wr_done_q <= 1'b0;
            if (is_load(grant_sel)) begin
              rom_addr_q <= Endereco;
              state_q    <= RD_WAIT;
            end else begin
              state_q <= WR;
            end
          end
        end
        // The ROM registers its address one edge after we drive it, so data is
        // sampled one edge past the nominal latency count.
        RD_WAIT: begin
          if (cnt_q == LAT) begin
            rdata_q <= rom_data;
            state_q <= RD_CAP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RD_CAP: begin
          if (sel_q == REQ_A) begin
            a_q     <= {8'h00, rdata_q};
            fim_a_q <= 1'b1;
          end else begin
            b_q     <= {8'h00, rdata_q};
            fim_b_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        WR: begin
          if (!wr_done_q) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= (sel_q == REQ_R) ? addr_q + RESTO_BASE : addr_q;
            ram_wdata_q <= (sel_q == REQ_R) ? resto : result;
            wr_done_q   <= 1'b1;
          end else begin
            fim_c_q       <= (sel_q == REQ_C);
            fim_r_q       <= (sel_q == REQ_R);
            store_count_q <= store_count_q + 8'd1;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr    = rom_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign A           = a_q;
  assign B           = b_q;
  assign FimA        = fim_a_q;
  assign FimB        = fim_b_q;
  assign FimC        = fim_c_q;
  assign FimResto    = fim_r_q;
  assign busy        = (state_q != IDLE);
  assign store_count = store_count_q;

endmodule
